alu_2_seq: RTL and testbench

Digit-serial sequencer wrapping one `alu_2` slice to perform WIDTH-bit AND/XOR/add/subtract operations. It latches wide operands, issues them to the slice 2 bits per issue, least-significant digit first, and chains each returned `carry_out` into the next digit's `carry_in`. It reassembles the `zout` digits into a WIDTH-bit result and reports final overflow and carry. It sits directly upstream of the `alu_2` inputs and directly downstream of its outputs.

---
 rtl/alu_2_seq.sv | 188 ++++++++++++++++++
 tb/tb_alu_2_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_2_seq.sv
// alu_2_seq -- digit-serial sequencer around a single 2-bit alu_2 slice.
//
// Latches WIDTH-bit operands and issues them to the slice one 2-bit digit
// at a time, least-significant digit first. Each digit's returned carry is
// chained into the next digit's carry_in. The returned zout digits are
// reassembled into a WIDTH-bit result. The final (most-significant) digit's
// overflow and carry are reported as the operation flags.
//
// Parameters:
//   WIDTH   - operand width, even and >= 2 (digit count D = WIDTH/2)
//   ALU_LAT - fixed slice latency, issue to zout/overflow/carry_out valid
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     operation request, accepted only when idle
//   x, y, cin                 operands and initial carry, sampled on accept
//   cmpl_x, cmpl_y, op_and,
//   op_xor, op_arith          operation controls, sampled on accept
//   busy                      high from the cycle after accept through done
//   done                      one-cycle pulse, result and flags valid
//   result, overflow,
//   carry_out                 assembled result and final-digit flags
//   alu_*  (outputs)          slice inputs, nonzero only in the issue cycle
//   alu_zout, alu_overflow,
//   alu_carry_out (inputs)    slice outputs, ALU_LAT cycles after issue
module alu_2_seq #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             cmpl_x,
  input  logic             cmpl_y,
  input  logic             op_and,
  input  logic             op_xor,
  input  logic             op_arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry_out,
  output logic [1:0]       alu_xin,
  output logic [1:0]       alu_yin,
  output logic             alu_carry_in,
  output logic             alu_end_bar,
  output logic             alu_cmpl_x,
  output logic             alu_cmpl_y,
  output logic             alu_op_and,
  output logic             alu_op_xor,
  output logic             alu_op_arith,
  input  logic [1:0]       alu_zout,
  input  logic             alu_overflow,
  input  logic             alu_carry_out
);

  localparam int D     = WIDTH / 2;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   x_r;
  logic [WIDTH-1:0]   y_r;
  logic               cin_r;
  logic               cmpl_x_r;
  logic               cmpl_y_r;
  logic               op_and_r;
  logic               op_xor_r;
  logic               op_arith_r;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               carry_r;
  logic               last_digit;
  logic               capture;
  logic               accept;

  assign last_digit = (idx == IDX_W'(D - 1));
  // The slice result for the current digit is valid exactly when the wait
  // counter reaches zero; nothing is captured outside WAIT, so slice output
  // still draining after a reset is never observed.
  assign capture    = (state == S_WAIT) && (cnt == '0);
  assign accept     = (state == S_IDLE) && start;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (capture) state_nxt = last_digit ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Slice inputs are held at zero except in the single issue cycle.
  always_comb begin
    alu_xin      = 2'b00;
    alu_yin      = 2'b00;
    alu_carry_in = 1'b0;
    alu_end_bar  = 1'b0;
    alu_cmpl_x   = 1'b0;
    alu_cmpl_y   = 1'b0;
    alu_op_and   = 1'b0;
    alu_op_xor   = 1'b0;
    alu_op_arith = 1'b0;
    if (state == S_ISSUE) begin
      alu_xin      = x_r[2*int'(idx) +: 2];
      alu_yin      = y_r[2*int'(idx) +: 2];
      alu_carry_in = (idx == '0) ? cin_r : carry_r;
      alu_end_bar  = !last_digit;
      alu_cmpl_x   = cmpl_x_r;
      alu_cmpl_y   = cmpl_y_r;
      alu_op_and   = op_and_r;
      alu_op_xor   = op_xor_r;
      alu_op_arith = op_arith_r;
    end
  end

  // Operand capture on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      x_r        <= x;
      y_r        <= y;
      cin_r      <= cin;
      cmpl_x_r   <= cmpl_x;
      cmpl_y_r   <= cmpl_y;
      op_and_r   <= op_and;
      op_xor_r   <= op_xor;
      op_arith_r <= op_arith;
    end
  end

  // Sequencing, digit capture and flag update
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      carry_r   <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx       <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
          end
        end
        S_ISSUE: cnt <= CNT_W'(ALU_LAT - 1);
        S_WAIT: begin
          if (capture) begin
            result[2*int'(idx) +: 2] <= alu_zout;
            carry_r                  <= alu_carry_out;
            if (last_digit) begin
              overflow  <= alu_overflow;
              carry_out <= alu_carry_out;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_2_seq.sv
// Testbench for alu_2_seq: behavioural 2-bit alu_2 slice with fixed latency,
// whole-word reference model, cycle-by-cycle checks of the slice interface.
module tb_alu_2_seq;

  localparam int W = 8;
  localparam int L = 7;
  localparam int D = W / 2;
  localparam int OP_CYC = D * (L + 1) + 1;  // start-accept to done, in cycles

  logic         clk = 1'b0;
  logic         rst, start, cin, cmpl_x, cmpl_y, op_and, op_xor, op_arith;
  logic [W-1:0] x, y;
  logic         busy, done, overflow, carry_out;
  logic [W-1:0] result;
  logic [1:0]   alu_xin, alu_yin, alu_zout;
  logic         alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y;
  logic         alu_op_and, alu_op_xor, alu_op_arith;
  logic         alu_overflow, alu_carry_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_2_seq #(.WIDTH(W), .ALU_LAT(L)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .cin(cin),
    .cmpl_x(cmpl_x), .cmpl_y(cmpl_y), .op_and(op_and), .op_xor(op_xor),
    .op_arith(op_arith), .busy(busy), .done(done), .result(result),
    .overflow(overflow), .carry_out(carry_out),
    .alu_xin(alu_xin), .alu_yin(alu_yin), .alu_carry_in(alu_carry_in),
    .alu_end_bar(alu_end_bar), .alu_cmpl_x(alu_cmpl_x), .alu_cmpl_y(alu_cmpl_y),
    .alu_op_and(alu_op_and), .alu_op_xor(alu_op_xor), .alu_op_arith(alu_op_arith),
    .alu_zout(alu_zout), .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out)
  );

  // Behavioural 2-bit slice: {overflow, carry_out, zout}
  function automatic logic [3:0] slice_f(input logic [1:0] xi, yi,
                                         input logic ci, cx, cy, oa, ox, oar);
    logic [1:0] a, b;
    logic [2:0] s;
    logic       c1;
    a = cx ? ~xi : xi;
    b = cy ? ~yi : yi;
    if (oar) begin
      s  = {1'b0, a} + {1'b0, b} + {2'b00, ci};
      c1 = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
      return {c1 ^ s[2], s[2], s[1:0]};
    end else if (oa) return {2'b00, a & b};
    else if (ox) return {2'b00, a ^ b};
    return 4'b0000;
  endfunction

  logic [3:0] pipe [L];
  always_ff @(posedge clk) begin
    pipe[0] <= slice_f(alu_xin, alu_yin, alu_carry_in, alu_cmpl_x, alu_cmpl_y,
                       alu_op_and, alu_op_xor, alu_op_arith);
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign alu_zout      = pipe[L-1][1:0];
  assign alu_carry_out = pipe[L-1][2];
  assign alu_overflow  = pipe[L-1][3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] slice_bus();
    return {alu_xin, alu_yin, alu_carry_in, alu_end_bar, alu_cmpl_x, alu_cmpl_y,
            alu_op_and, alu_op_xor, alu_op_arith};
  endfunction

  // Must be called at a negedge with rst low. mode: 0 normal,
  // 1 extra start pulses while busy (S+5 and DONE), 2 reset at S+12.
  // Returns at the negedge of the cycle after DONE.
  task automatic run_op(input logic [W-1:0] xv, yv, input logic ci, cx, cy,
                        oa, ox, oar, input int mode);
    logic [W-1:0] a, b, exp_res;
    logic [W:0]   s;
    logic         exp_c, exp_v, aborted, issue, cink;
    logic [10:0]  exp_sl;
    longint       m;
    int           k;
    a = cx ? ~xv : xv;
    b = cy ? ~yv : yv;
    exp_c = 1'b0;
    exp_v = 1'b0;
    if (oar) begin
      s       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      exp_res = s[W-1:0];
      exp_c   = s[W];
      exp_v   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end else if (oa) exp_res = a & b;
    else if (ox) exp_res = a ^ b;
    else exp_res = '0;

    x = xv; y = yv; cin = ci; cmpl_x = cx; cmpl_y = cy;
    op_and = oa; op_xor = ox; op_arith = oar; start = 1'b1;
    for (int c = 1; c <= OP_CYC; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      aborted = (mode == 2) && (c >= 13);
      issue   = !aborted && ((c - 1) % (L + 1) == 0) && (c < OP_CYC);
      exp_sl  = '0;
      if (issue) begin
        k = (c - 1) / (L + 1);
        m = (longint'(1) << (2 * k)) - 1;
        if (k == 0) cink = ci;
        else if (oar)
          cink = 1'(((longint'(a) & m) + (longint'(b) & m) + longint'(ci)) >> (2 * k));
        else cink = 1'b0;
        exp_sl = {xv[2*k +: 2], yv[2*k +: 2], cink, (k != D - 1), cx, cy, oa, ox, oar};
      end
      chk("slice_if", 32'(slice_bus()), 32'(exp_sl));
      chk("busy", busy, !aborted);
      chk("done", done, !aborted && (c == OP_CYC));
      if (!aborted && c == OP_CYC) begin
        chk("result", result, exp_res);
        chk("carry_out", carry_out, exp_c);
        chk("overflow", overflow, exp_v);
      end
      if (mode == 2 && c == 13) begin
        chk("rst_result", result, 0);
        chk("rst_flags", {overflow, carry_out}, 0);
      end
      if (mode == 1 && (c == 5 || c == OP_CYC)) begin
        x = ~xv; y = ~yv; cin = ~ci; op_and = 1'b1; op_xor = 1'b1;
        start = 1'b1;
      end
      if (mode == 2 && c == 12) rst = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_slice", 32'(slice_bus()), 0);
    if (mode == 2) chk("hold_result", result, 0);
    else begin
      chk("hold_result", result, exp_res);
      chk("hold_flags", {overflow, carry_out}, {exp_v, exp_c});
    end
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    logic         rc, rcx, rcy;
    int           sel;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0;
    cmpl_x = 1'b0; cmpl_y = 1'b0; op_and = 1'b0; op_xor = 1'b0; op_arith = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy_done", {busy, done}, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {overflow, carry_out}, 0);
    chk("reset_slice", 32'(slice_bus()), 0);

    // rst and start together: reset wins
    start = 1'b1; x = 8'hAA; op_arith = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    @(negedge clk);
    chk("rst_start_slice", 32'(slice_bus()), 0);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);  // add
    run_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);  // subtract
    run_op(8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);  // and
    run_op(8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);  // xor, busy pulses
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);  // back-to-back
    run_op(8'hC3, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);  // reset mid-op
    run_op(8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);  // after reset

    for (int n = 0; n < 20; n++) begin
      rx  = W'($urandom);
      ry  = W'($urandom);
      rc  = 1'($urandom);
      rcx = 1'($urandom);
      rcy = 1'($urandom);
      sel = $urandom_range(0, 2);
      run_op(rx, ry, rc, rcx, rcy, sel == 1, sel == 2, sel == 0, 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
